// File: rtl/regfile_wb_pkg.sv
// Shared levels, zero constants and forwarding-source encoding for the integer register file.
// The reset-asserted level is shared with the pipeline registers that are moving to active-low reset.
package regfile_wb_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    localparam logic AVAIL        = 1'b1;
    localparam logic UNAVAIL      = 1'b0;
    localparam logic RST_ASSERTED = 1'b0;

    localparam logic [RF_DATA_W-1:0] ZEROWORD = '0;
    localparam logic [RF_ADDR_W-1:0] ZEROREG  = '0;

    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_EX,
        SRC_MEM,
        SRC_WB,
        SRC_RF
    } fwd_src_t;

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-port operand selector: zero, EX, MEM, WB, then storage, youngest producer first.
// Purely combinational, zero latency, no backpressure (a pending EX load is skipped; stallreq covers it).
module regfile_fwd_mux
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ex_wvalid,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wvalid,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_wvalid,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] rdata
);

    fwd_src_t src;

    always_comb begin
        src = SRC_RF;
        if (re == UNAVAIL || raddr == ADDR_W'(ZEROREG)) begin
            src = SRC_ZERO;
        end else if (ex_wvalid && !ex_is_load && ex_waddr == raddr) begin
            src = SRC_EX;
        end else if (mem_wvalid && mem_waddr == raddr) begin
            src = SRC_MEM;
        end else if (wb_wvalid && wb_waddr == raddr) begin
            src = SRC_WB;
        end
    end

    always_comb begin
        rdata = rf_rdata;
        case (src)
            SRC_ZERO: rdata = DATA_W'(ZEROWORD);
            SRC_EX:   rdata = ex_wdata;
            SRC_MEM:  rdata = mem_wdata;
            SRC_WB:   rdata = wb_wdata;
            default:  rdata = rf_rdata;
        endcase
    end

endmodule

// File: rtl/regfile_wb.sv
// 32x32 integer register file fed by MEM/WB write-back, two forwarding read ports and a load-use stall request.
// Writes land one edge later, reads are combinational; stallreq is the only backpressure it raises.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wvalid_wb,
    input  logic [ADDR_W-1:0] waddr_wb,
    input  logic [DATA_W-1:0] wdata_wb,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              ex_wvalid,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wvalid,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              stallreq
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;
    logic              in_reset;
    logic              ex_load_pending;
    logic              hazard1;
    logic              hazard2;

    assign in_reset = (rst == RST_ASSERTED);

    // x0 is cleared by reset and never written, so storage reads of x0 are also 0.
    always_ff @(posedge clk) begin
        if (rst == RST_ASSERTED) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= DATA_W'(ZEROWORD);
            end
        end else if (wvalid_wb && waddr_wb != ADDR_W'(ZEROREG)) begin
            regs[waddr_wb] <= wdata_wb;
        end
    end

    regfile_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
        .re         (re1),
        .raddr      (raddr1),
        .ex_wvalid  (ex_wvalid),
        .ex_waddr   (ex_waddr),
        .ex_wdata   (ex_wdata),
        .ex_is_load (ex_is_load),
        .mem_wvalid (mem_wvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .wb_wvalid  (wvalid_wb),
        .wb_waddr   (waddr_wb),
        .wb_wdata   (wdata_wb),
        .rf_rdata   (regs[raddr1]),
        .rdata      (fwd1)
    );

    regfile_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
        .re         (re2),
        .raddr      (raddr2),
        .ex_wvalid  (ex_wvalid),
        .ex_waddr   (ex_waddr),
        .ex_wdata   (ex_wdata),
        .ex_is_load (ex_is_load),
        .mem_wvalid (mem_wvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .wb_wvalid  (wvalid_wb),
        .wb_waddr   (waddr_wb),
        .wb_wdata   (wdata_wb),
        .rf_rdata   (regs[raddr2]),
        .rdata      (fwd2)
    );

    assign ex_load_pending = ex_wvalid && ex_is_load && (ex_waddr != ADDR_W'(ZEROREG));
    assign hazard1         = ex_load_pending && re1 && (raddr1 == ex_waddr);
    assign hazard2         = ex_load_pending && re2 && (raddr2 == ex_waddr);

    assign rdata1   = in_reset ? DATA_W'(ZEROWORD) : fwd1;
    assign rdata2   = in_reset ? DATA_W'(ZEROWORD) : fwd2;
    assign stallreq = (!in_reset && (hazard1 || hazard2)) ? AVAIL : UNAVAIL;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed and randomized bench for regfile_wb against an array-based reference model.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wvalid_wb;
    logic [4:0]  waddr_wb;
    logic [31:0] wdata_wb;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic        ex_wvalid, ex_is_load;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        mem_wvalid;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] rdata1, rdata2;
    logic        stallreq;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk        (clk),
        .rst        (rst),
        .wvalid_wb  (wvalid_wb),
        .waddr_wb   (waddr_wb),
        .wdata_wb   (wdata_wb),
        .re1        (re1),
        .raddr1     (raddr1),
        .re2        (re2),
        .raddr2     (raddr2),
        .ex_wvalid  (ex_wvalid),
        .ex_waddr   (ex_waddr),
        .ex_wdata   (ex_wdata),
        .ex_is_load (ex_is_load),
        .mem_wvalid (mem_wvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .stallreq   (stallreq)
    );

    // Architectural register state as seen after each clock edge.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wvalid_wb === 1'b1 && waddr_wb != 5'd0) begin
            model[waddr_wb] = wdata_wb;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wvalid_wb = 0; waddr_wb = 0; wdata_wb = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        ex_wvalid = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
        mem_wvalid = 0; mem_waddr = 0; mem_wdata = 0;
    endtask

    // Expected operand for one port; dc is set when a pending EX load makes the value don't-care.
    function automatic void exp_port(input logic re, input logic [4:0] a,
                                     output logic [31:0] v, output bit dc);
        dc = 0;
        v  = 32'h0;
        if (rst == 1'b0 || !re || a == 5'd0) v = 32'h0;
        else if (ex_wvalid && ex_waddr == a && ex_is_load) dc = 1;
        else if (ex_wvalid && ex_waddr == a) v = ex_wdata;
        else if (mem_wvalid && mem_waddr == a) v = mem_wdata;
        else if (wvalid_wb && waddr_wb == a) v = wdata_wb;
        else v = model[a];
    endfunction

    function automatic logic exp_stall();
        if (rst == 1'b0) return 1'b0;
        return ex_wvalid && ex_is_load && ex_waddr != 5'd0 &&
               ((re1 && raddr1 == ex_waddr) || (re2 && raddr2 == ex_waddr));
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] e1, e2;
        bit dc1, dc2;
        exp_port(re1, raddr1, e1, dc1);
        exp_port(re2, raddr2, e2, dc2);
        if (!dc1) chk({tag, "_rdata1"}, rdata1, e1);
        if (!dc2) chk({tag, "_rdata2"}, rdata2, e2);
        chk({tag, "_stallreq"}, {31'h0, stallreq}, {31'h0, exp_stall()});
    endtask

    initial begin
        idle();
        rst = 0;
        // Outputs held at zero in reset even with EX forwarding and a stall pattern present.
        re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 6;
        ex_wvalid = 1; ex_waddr = 3; ex_wdata = 32'hFFFF0000;
        tick();
        chk("rst_rdata1", rdata1, 32'h0);
        ex_is_load = 1; ex_waddr = 6;
        #1;
        chk("rst_rdata2", rdata2, 32'h0);
        chk("rst_stallreq", {31'h0, stallreq}, 32'h0);
        tick();
        idle();
        rst = 1;
        tick();

        re1 = 1; re2 = 1;
        for (int a = 1; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(32 - a);
            #1;
            chk("post_rst_p1", rdata1, 32'h0);
            chk("post_rst_p2", rdata2, 32'h0);
        end

        idle();
        wvalid_wb = 1; waddr_wb = 0; wdata_wb = 32'hDEADBEEF;
        tick();
        idle();
        re1 = 1; raddr1 = 0; re2 = 1; raddr2 = 0;
        #1;
        chk("x0_read", rdata1, 32'h0);

        idle();
        wvalid_wb = 1; waddr_wb = 5; wdata_wb = 32'h12345678;
        tick();
        idle();
        re1 = 1; raddr1 = 5;
        #1;
        chk("x5_read", rdata1, 32'h12345678);

        idle();
        wvalid_wb = 1; waddr_wb = 7; wdata_wb = 32'hA5A5A5A5;
        re2 = 1; raddr2 = 7;
        #1;
        chk("wb_bypass", rdata2, 32'hA5A5A5A5);
        tick();

        idle();
        wvalid_wb = 1; waddr_wb = 3; wdata_wb = 32'h1;
        tick();
        idle();
        re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 3;
        mem_wvalid = 1; mem_waddr = 3; mem_wdata = 32'h2;
        ex_wvalid = 1; ex_waddr = 3; ex_wdata = 32'h3;
        wvalid_wb = 1; waddr_wb = 3; wdata_wb = 32'h4;
        #1;
        chk("prio_ex", rdata1, 32'h3);
        chk("prio_ex_p2", rdata2, 32'h3);
        ex_wvalid = 0;
        #1;
        chk("prio_mem", rdata1, 32'h2);
        mem_wvalid = 0;
        #1;
        chk("prio_wb", rdata1, 32'h4);
        wvalid_wb = 0;
        #1;
        chk("prio_rf", rdata1, 32'h1);

        idle();
        ex_wvalid = 1; ex_is_load = 1; ex_waddr = 9; ex_wdata = 32'h77;
        re2 = 1; raddr2 = 9;
        #1;
        chk("load_use_stall", {31'h0, stallreq}, 32'h1);
        tick();
        ex_wvalid = 0; ex_is_load = 0;
        mem_wvalid = 1; mem_waddr = 9; mem_wdata = 32'h55;
        #1;
        chk("load_use_release", {31'h0, stallreq}, 32'h0);
        chk("load_use_mem", rdata2, 32'h55);
        idle();
        ex_wvalid = 1; ex_is_load = 1; ex_waddr = 9;
        re2 = 0; raddr2 = 9;
        #1;
        chk("load_use_re_off", {31'h0, stallreq}, 32'h0);

        idle();
        wvalid_wb = 1; waddr_wb = 4; wdata_wb = 32'h11111111;
        tick();
        rst = 0;
        waddr_wb = 4; wdata_wb = 32'h22222222;
        re1 = 1; raddr1 = 4; re2 = 1; raddr2 = 5;
        #1;
        chk("rst_mid_rdata1", rdata1, 32'h0);
        chk("rst_mid_rdata2", rdata2, 32'h0);
        tick();
        rst = 1;
        wvalid_wb = 0;
        #1;
        chk("rst_mid_x4", rdata1, 32'h0);
        chk("rst_mid_x5", rdata2, 32'h0);

        // Randomized traffic with small address range so producers collide often.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 59) != 0);
            wvalid_wb  = $urandom_range(0, 1);
            waddr_wb   = 5'($urandom_range(0, 3) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            wdata_wb   = $urandom;
            re1        = ($urandom_range(0, 4) != 0);
            raddr1     = 5'($urandom_range(0, 3) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            re2        = ($urandom_range(0, 4) != 0);
            raddr2     = 5'($urandom_range(0, 3) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            ex_wvalid  = ($urandom_range(0, 2) == 0);
            ex_waddr   = 5'($urandom_range(0, 7));
            ex_wdata   = $urandom;
            ex_is_load = ($urandom_range(0, 3) == 0);
            mem_wvalid = ($urandom_range(0, 2) == 0);
            mem_waddr  = 5'($urandom_range(0, 7));
            mem_wdata  = $urandom;
            #1;
            check_model("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Integer register file: 32 x 32-bit. It is the consumer end of the write-back interface driven by the MEM/WB pipeline register.
- Serves two combinational read ports to the decode stage.
- Operand forwarding priority: EX result, then MEM result, then WB write, then the storage array.
- Raises a load-use stall request toward the stall controller.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width (2^ADDR_W registers)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- wvalid_wb  in  1  write-back enable from MEM/WB
- waddr_wb  in  ADDR_W  write-back destination register
- wdata_wb  in  DATA_W  write-back data
- re1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read address, port 1
- re2  in  1  read enable, port 2
- raddr2  in  ADDR_W  read address, port 2
- ex_wvalid  in  1  EX stage will write a register
- ex_waddr  in  ADDR_W  EX destination register
- ex_wdata  in  DATA_W  EX ALU result
- ex_is_load  in  1  EX instruction is a load (data not yet available)
- mem_wvalid  in  1  MEM stage will write a register
- mem_waddr  in  ADDR_W  MEM destination register
- mem_wdata  in  DATA_W  MEM result (load data resolved)
- rdata1  out  DATA_W  operand 1
- rdata2  out  DATA_W  operand 2
- stallreq  out  1  load-use stall request from decode

Behaviour:
- Reset:
  - Reset is synchronous and active-low.
  - While rst==0 at a rising clk edge, all 32 registers clear to 0.
  - While rst==0, rdata1, rdata2 and stallreq are held at 0 combinationally.
- Write:
  - At a rising clk edge with rst==1, wvalid_wb==1 and waddr_wb!=0: regs[waddr_wb] <= wdata_wb.
  - Writes to x0 are discarded; x0 always reads 0.
- Read (combinational, zero latency). Per port p, evaluated in this order:
  1. re_p==0 or raddr_p==0 -> rdata_p = 0.
  2. ex_wvalid && ex_waddr==raddr_p && !ex_is_load -> ex_wdata.
  3. mem_wvalid && mem_waddr==raddr_p -> mem_wdata.
  4. wvalid_wb && waddr_wb==raddr_p -> wdata_wb (same-cycle write bypass).
  5. Otherwise regs[raddr_p].
- Load-use hazard:
  - stallreq = ex_wvalid && ex_is_load && ex_waddr!=0 && ((re1 && raddr1==ex_waddr) || (re2 && raddr2==ex_waddr)).
  - When a port matches a pending EX load, EX forwarding is skipped for that port and its rdata is don't-care. The stall holds decode, and the value is supplied next cycle via MEM forwarding.
- Simultaneous matches:
  - When EX, MEM and WB all target the same register, the youngest producer (EX) wins.
  - Both ports may hit the same source in the same cycle.
- Stall independence: the block ignores pipeline stall. Upstream holds wvalid_wb low during flush/stall bubbles, so no write occurs.
- Reset mid-operation: a write presented in the same cycle as rst==0 is dropped; reset wins.

Decomposition:
- Shared defines: avail/unavail levels, zeroword, zeroreg, and reset-asserted level (0). The reset level constant is used by this block and by the pipeline registers migrating to active-low.
- Sub-module: regfile_fwd_mux, a combinational priority selector, instantiated once per read port. Storage, write logic and stallreq stay in regfile_wb.

Test Plan:
- Reset, then read x1..x31 with re1=re2=1 -> all 0. Write x0<=0xDEADBEEF -> x0 still reads 0.
- Write x5<=0x12345678 via WB, then read raddr1=5 next cycle with no forwarding active -> 0x12345678.
- Same-cycle bypass: wvalid_wb=1, waddr_wb=7, wdata_wb=0xA5A5A5A5 while raddr2=7 -> rdata2=0xA5A5A5A5 in the same cycle.
- Priority: x3 holds 0x1; MEM forwards 0x2 to x3, EX forwards 0x3 to x3 -> rdata1=0x3. Deassert ex_wvalid -> 0x2. Deassert mem_wvalid -> 0x1.
- Load-use: ex_is_load=1, ex_waddr=9, raddr2=9, re2=1 -> stallreq=1. Next cycle, same address via MEM with mem_wdata=0x55 and EX idle -> stallreq=0, rdata2=0x55. With re2=0 -> stallreq=0.
- Pulse rst low mid-sequence with wvalid_wb=1 to x4 -> x4 reads 0 afterward, and outputs read 0 while reset is asserted.
